scr_frame_ctrl: RTL and testbench

Frame sequencer for the 16FSK transmit path. It owns the bit scrambler and frames each transmission as a preamble, an optional sync word and a scrambled payload. It sits between the upstream payload bit source and the FSK symbol mapper. It reseeds the scrambler at the start of every frame and advances it only on accepted payload bits, so the receiver descrambler stays bit-aligned.

---
 rtl/tx_pkg.sv | 20 ++
 rtl/scr_lfsr.sv | 34 +++
 rtl/scr_frame_ctrl.sv | 163 ++++++++++++++++
 tb/tb_scr_frame_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// tx_pkg
// Shared definitions for the 16FSK transmit path: frame sequencer state
// encoding, scrambler seed/taps and the sync word.
// No ports.
package tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SYNC = 3'd2,
        PAY  = 3'd3,
        DONE = 3'd4
    } tx_state_e;

    localparam logic [9:0]  SCR_SEED_DEFAULT = 10'b0001011101;
    localparam logic [15:0] SYNC_WORD        = 16'hEB90;
    localparam int          SCR_TAP_A        = 9;
    localparam int          SCR_TAP_B        = 6;

endpackage

// File: rtl/scr_lfsr.sv
// scr_lfsr
// 10-bit Fibonacci scrambler register. Shifts left, feedback enters at bit 0.
// Ports:
//   clk, rst    - clock, synchronous active-high reset (reset loads seed)
//   load        - load seed (has priority over adv)
//   seed[9:0]   - value loaded on reset and on load
//   adv         - advance one step
//   state[9:0]  - current register
//   key         - scrambling key bit (state[0])
module scr_lfsr
    import tx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [9:0] seed,
    input  logic       adv,
    output logic [9:0] state,
    output logic       key
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= seed;
        end else if (load) begin
            state <= seed;
        end else if (adv) begin
            state <= {state[8:0], state[SCR_TAP_B] ^ state[SCR_TAP_A]};
        end
    end

    assign key = state[0];

endmodule

// File: rtl/scr_frame_ctrl.sv
// scr_frame_ctrl
// Frame sequencer for the 16FSK transmit path: preamble, optional sync word,
// scrambled payload. Scrambler is reseeded at each frame start and advanced
// only on accepted payload bits.
// Build option: SCR_FRAME_CTRL_SYNC_EN - when defined, 16'hEB90 is sent MSB
// first between preamble and payload.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   start, len[LEN_W-1:0]            - frame request and payload bit count
//   busy, frame_done                 - frame in progress / end-of-frame pulse
//   in_valid, in_ready, in_data      - payload bits from upstream
//   out_valid, out_ready, out_data   - framed bits to the symbol mapper
//   scr_state[9:0]                   - scrambler register (debug)
//
// state | meaning
// IDLE  | waiting for start
// PRE   | sending alternating 1,0,... preamble
// SYNC  | sending sync word (only with SCR_FRAME_CTRL_SYNC_EN)
// PAY   | passing scrambled payload through, zero latency
// DONE  | one-cycle frame_done pulse
module scr_frame_ctrl
    import tx_pkg::*;
#(
    parameter int         PRE_LEN = 32,
    parameter int         LEN_W   = 9,
    parameter logic [9:0] SEED    = SCR_SEED_DEFAULT
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             frame_done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_data,
    output logic [9:0]       scr_state
);

    tx_state_e        st;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic             hdr_valid;
    logic             hdr_data;
    logic             key;
    logic             lfsr_load;
    logic             lfsr_adv;
    logic             in_pay;

    assign in_pay    = (st == PAY);
    assign lfsr_load = (st == IDLE) && start;
    assign lfsr_adv  = in_pay && in_valid && out_ready;

    // Payload is a pure pass-through; every other state drives registered bits.
    assign out_valid = in_pay ? in_valid : hdr_valid;
    assign out_data  = in_pay ? (in_data ^ key) : hdr_data;
    assign in_ready  = in_pay && out_ready;

    scr_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (SEED),
        .adv   (lfsr_adv),
        .state (scr_state),
        .key   (key)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= IDLE;
            cnt        <= '0;
            len_q      <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            hdr_valid  <= 1'b0;
            hdr_data   <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (start) begin
                        st        <= PRE;
                        cnt       <= '0;
                        len_q     <= len;
                        busy      <= 1'b1;
                        hdr_valid <= 1'b1;
                        hdr_data  <= 1'b1;
                    end
                end
                PRE: begin
                    if (hdr_valid && out_ready) begin
                        if (cnt == LEN_W'(PRE_LEN - 1)) begin
                            cnt <= '0;
`ifdef SCR_FRAME_CTRL_SYNC_EN
                            st       <= SYNC;
                            hdr_data <= SYNC_WORD[15];
`else
                            hdr_valid <= 1'b0;
                            hdr_data  <= 1'b0;
                            if (len_q == '0) begin
                                st         <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                st <= PAY;
                            end
`endif
                        end else begin
                            cnt      <= cnt + 1'b1;
                            hdr_data <= ~hdr_data;
                        end
                    end
                end
`ifdef SCR_FRAME_CTRL_SYNC_EN
                SYNC: begin
                    if (hdr_valid && out_ready) begin
                        if (cnt == LEN_W'(15)) begin
                            cnt       <= '0;
                            hdr_valid <= 1'b0;
                            hdr_data  <= 1'b0;
                            if (len_q == '0) begin
                                st         <= DONE;
                                frame_done <= 1'b1;
                            end else begin
                                st <= PAY;
                            end
                        end else begin
                            cnt      <= cnt + 1'b1;
                            // next bit is the one after the bit just sent
                            hdr_data <= SYNC_WORD[4'd14 - cnt[3:0]];
                        end
                    end
                end
`endif
                PAY: begin
                    if (in_valid && out_ready) begin
                        if (cnt == len_q - LEN_W'(1)) begin
                            st         <= DONE;
                            frame_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    st         <= IDLE;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    cnt        <= '0;
                end
                default: begin
                    st        <= IDLE;
                    busy      <= 1'b0;
                    hdr_valid <= 1'b0;
                    hdr_data  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr_frame_ctrl.sv
module tb_scr_frame_ctrl;
    import tx_pkg::*;

    localparam int         PRE_LEN = 32;
    localparam int         LEN_W   = 9;
    localparam logic [9:0] SEED    = 10'b0001011101;
`ifdef SCR_FRAME_CTRL_SYNC_EN
    localparam int         SYNC_LEN = 16;
`else
    localparam int         SYNC_LEN = 0;
`endif
    localparam logic [15:0] SYNC_EXP = 16'hEB90;
    localparam int          BUDGET   = 2000;

    // hand-computed scrambler states after n payload bits
    localparam logic [9:0] S1 = 10'b0010111011;
    localparam logic [9:0] S2 = 10'b0101110110;
    localparam logic [9:0] S4 = 10'b0111011010;
    localparam logic [9:0] S8 = 10'b0110101100;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             frame_done;
    logic             in_valid;
    logic             in_ready;
    logic             in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_data;
    logic [9:0]       scr_state;

    int total = 0;
    int bad   = 0;

    scr_frame_ctrl #(.PRE_LEN(PRE_LEN), .LEN_W(LEN_W), .SEED(SEED)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .frame_done (frame_done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .scr_state  (scr_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [15:0] in_bits;   // payload bit i at index i
        logic [15:0] exp_out;   // expected scrambled bit i at index i
        logic [9:0]  exp_scr;   // scrambler state after the frame
        bit          stall;     // random out_ready / in_valid
        int          glitch_at; // cycle of an ignored mid-frame start, -1 none
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called just after a negedge while the DUT is idle; returns just after
    // the negedge of the first idle cycle following the frame.
    task automatic run_frame(input vec_t v);
        int  xfer;
        int  hdr_n;
        int  total_x;
        int  cyc;
        int  pidx;
        bit  hold_pending;
        logic hold_data;
        logic exp_bit;
        xfer = 0;
        cyc = 0;
        hdr_n = PRE_LEN + SYNC_LEN;
        total_x = hdr_n + v.len;
        hold_pending = 0;
        hold_data = 1'b0;
        start = 1'b1;
        len = LEN_W'(v.len);
        while (xfer < total_x && cyc < BUDGET) begin
            @(negedge clk);
            start = (cyc == v.glitch_at);
            len = '0;
            out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pidx = xfer - hdr_n;
            if (pidx >= 0) begin
                in_valid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data = v.in_bits[pidx];
            end else begin
                in_valid = 1'b1;
                in_data = 1'b1;
            end
            #1;
            if (cyc == 0) check("busy_after_start", busy, 1);
            if (xfer < hdr_n) begin
                check("hdr_valid", out_valid, 1);
                check("hdr_in_ready", in_ready, 0);
                if (hold_pending) check("stall_hold", out_data, hold_data);
                if (out_ready) begin
                    if (xfer < PRE_LEN) exp_bit = ((xfer % 2) == 0) ? 1'b1 : 1'b0;
                    else exp_bit = SYNC_EXP[15 - (xfer - PRE_LEN)];
                    check(xfer < PRE_LEN ? "pre_bit" : "sync_bit", out_data, exp_bit);
                    xfer++;
                    hold_pending = 0;
                end else begin
                    hold_pending = 1;
                    hold_data = out_data;
                end
            end else begin
                check("pay_valid", out_valid, in_valid);
                check("pay_ready", in_ready, out_ready);
                if (in_valid && out_ready) begin
                    check("pay_bit", out_data, v.exp_out[pidx]);
                    xfer++;
                end
            end
            cyc++;
        end
        check("frame_xfers", xfer, total_x);
        start = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        #1;
        check("done_pulse", frame_done, 1);
        check("done_busy", busy, 1);
        check("done_valid", out_valid, 0);
        check("done_in_ready", in_ready, 0);
        @(negedge clk);
        #1;
        check("done_clear", frame_done, 0);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        check("frame_scr", scr_state, v.exp_scr);
    endtask

    initial begin
        // len, in, exp_out, exp_scr, stall, glitch
        vecs[0] = '{4, 16'h0000, 16'h000B, S4, 1'b0, -1};
        vecs[1] = '{0, 16'h0000, 16'h0000, SEED, 1'b0, -1};
        vecs[2] = '{8, 16'h00FF, 16'h0094, S8, 1'b1, -1};
        vecs[3] = '{8, 16'h00A5, 16'h00CE, S8, 1'b0, 10};
        vecs[4] = '{4, 16'h0000, 16'h000B, S4, 1'b1, 40};
        vecs[5] = '{1, 16'h0001, 16'h0000, S1, 1'b0, -1};
        vecs[6] = '{0, 16'h0000, 16'h0000, SEED, 1'b1, 5};

        rst = 1'b1;
        start = 1'b0;
        len = '0;
        in_valid = 1'b0;
        in_data = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_scr", scr_state, SEED);

        // frames back to back, each new start in the first idle cycle
        for (int i = 0; i < 7; i++) run_frame(vecs[i]);

        // abort after two payload bits
        start = 1'b1;
        len = LEN_W'(4);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 1'b0;
        @(negedge clk);
        start = 1'b0;
        len = '0;
        repeat (PRE_LEN + SYNC_LEN + 2) @(negedge clk);
        #1;
        check("abort_pre_scr", scr_state, S2);
        check("abort_pre_ready", in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_done", frame_done, 0);
        check("abort_scr", scr_state, SEED);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("abort_stays_idle", out_valid, 0);
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
